// File: rtl/sync_gen.sv
// sync_gen -- video timing generator.
// Free-running h/v position counters with registered sync, active-picture and
// line/frame start flags. Every flag is computed from the next position and
// registered alongside it, so flags always describe the h/v shown in the same
// cycle. All state advances only on enabled clock edges.
module sync_gen #(
    parameter int H_ACTIVE = 720,
    parameter int H_FPORCH = 12,
    parameter int H_SYNC   = 64,
    parameter int H_BPORCH = 68,
    parameter int V_ACTIVE = 576,
    parameter int V_FPORCH = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BPORCH = 39,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int W        = 13
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    output logic         HSYNC,
    output logic         VSYNC,
    output logic         ACTIVE,
    output logic         LINE_START,
    output logic         FRAME_START,
    output logic [W-1:0] h,
    output logic [W-1:0] v
);

    localparam int H_TOTAL  = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int V_TOTAL  = V_ACTIVE + V_FPORCH + V_SYNC + V_BPORCH;
    localparam int HS_START = H_ACTIVE + H_FPORCH;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FPORCH;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [W-1:0] H_LAST     = W'(H_TOTAL - 1);
    localparam logic [W-1:0] V_LAST     = W'(V_TOTAL - 1);
    localparam logic [W-1:0] H_ACTIVE_W = W'(H_ACTIVE);
    localparam logic [W-1:0] V_ACTIVE_W = W'(V_ACTIVE);
    localparam logic [W-1:0] HS_START_W = W'(HS_START);
    localparam logic [W-1:0] HS_END_W   = W'(HS_END);
    localparam logic [W-1:0] VS_START_W = W'(VS_START);
    localparam logic [W-1:0] VS_END_W   = W'(VS_END);

    // Parameter sanity: totals must fit the counters; only porches may be zero.
    generate
        if (W <= 0 || W > 30) begin : g_bad_width
            $error("sync_gen: W must be in 1..30");
        end
        if (H_TOTAL >= 2**W || V_TOTAL >= 2**W) begin : g_bad_total
            $error("sync_gen: H_TOTAL/V_TOTAL do not fit in W bits");
        end
        if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0) begin : g_bad_zero
            $error("sync_gen: active and sync widths must be non-zero");
        end
        if (H_FPORCH < 0 || H_BPORCH < 0 || V_FPORCH < 0 || V_BPORCH < 0) begin : g_bad_porch
            $error("sync_gen: porches must not be negative");
        end
    endgenerate

    logic [W-1:0] h_q, h_d;
    logic [W-1:0] v_q, v_d;
    logic         hsync_q, hsync_d;
    logic         vsync_q, vsync_d;
    logic         active_q, active_d;
    logic         line_start_q, line_start_d;
    logic         frame_start_q, frame_start_d;

    // Next position: h wraps at the end of the line, v steps only on that wrap.
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d = '0;
            end else begin
                v_d = v_q + 1'b1;
            end
        end
    end

    // Flags decoded from the next position so they register together with it.
    always_comb begin
        hsync_d       = ((h_d >= HS_START_W) && (h_d < HS_END_W)) ? HS_POL : ~HS_POL;
        vsync_d       = ((v_d >= VS_START_W) && (v_d < VS_END_W)) ? VS_POL : ~VS_POL;
        active_d      = (h_d < H_ACTIVE_W) && (v_d < V_ACTIVE_W);
        line_start_d  = (h_d == '0);
        frame_start_d = (h_d == '0) && (v_d == '0);
    end

    // Position and flag registers; reset lands on position (0,0) with its flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            active_q      <= 1'b1;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else if (EN) begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h           = h_q;
    assign v           = v_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign ACTIVE      = active_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: doc/sync_gen.md
SYNC_GEN -- requirements
Module: sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 720, active pixels per line.
REQ-002 SHALL have parameter H_FPORCH, default 12, front-porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 64, hsync width in pixels.
REQ-004 SHALL have parameter H_BPORCH, default 68, back-porch pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 576, active lines.
REQ-006 SHALL have parameter V_FPORCH, default 5, front-porch lines.
REQ-007 SHALL have parameter V_SYNC, default 5, vsync width in lines.
REQ-008 SHALL have parameter V_BPORCH, default 39, back-porch lines.
REQ-009 SHALL have parameter HS_POL, default 0, hsync asserted level (0 = active-low).
REQ-010 SHALL have parameter VS_POL, default 0, vsync asserted level.
REQ-011 SHALL have parameter W, default 13, h/v counter width.
REQ-012 SHALL have port CLK, input, 1, pixel clock.
REQ-013 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-014 SHALL have port EN, input, 1, pixel clock enable; all state advances only when high.
REQ-015 SHALL have port HSYNC, output, 1, horizontal sync at HS_POL.
REQ-016 SHALL have port VSYNC, output, 1, vertical sync at VS_POL.
REQ-017 SHALL have port ACTIVE, output, 1, active-picture flag.
REQ-018 SHALL have port LINE_START, output, 1, one-enabled-cycle pulse at h = 0.
REQ-019 SHALL have port FRAME_START, output, 1, one-enabled-cycle pulse at h = 0, v = 0.
REQ-020 SHALL have ports h and v, output, W each, current horizontal/vertical position.

Function
REQ-021 SHALL define H_TOTAL = H_ACTIVE+H_FPORCH+H_SYNC+H_BPORCH and V_TOTAL likewise.
REQ-022 SHALL, on each CLK edge with EN high, advance h by 1, wrapping h = H_TOTAL-1 -> 0 (h never equals H_TOTAL).
REQ-023 SHALL advance v by 1 in the same cycle h wraps, wrapping v = V_TOTAL-1 -> 0; v unchanged otherwise.
REQ-024 SHALL hold h, v and all flags unchanged while EN is low.
REQ-025 SHALL register HSYNC, VSYNC, ACTIVE, LINE_START, FRAME_START so that every flag describes the h/v value presented in the same cycle (zero relative latency).
REQ-026 SHALL assert HSYNC (= HS_POL) exactly for H_ACTIVE+H_FPORCH <= h < H_ACTIVE+H_FPORCH+H_SYNC; otherwise drive ~HS_POL.
REQ-027 SHALL assert VSYNC (= VS_POL) exactly for V_ACTIVE+V_FPORCH <= v < V_ACTIVE+V_FPORCH+V_SYNC, changing only together with v.
REQ-028 SHALL assert ACTIVE exactly when h < H_ACTIVE and v < V_ACTIVE.
REQ-029 SHALL assert LINE_START exactly when h = 0, and FRAME_START exactly when h = 0 and v = 0.
REQ-030 SHALL require H_TOTAL and V_TOTAL < 2^W; if violated, simulation SHALL report an error at elaboration.
REQ-031 SHALL treat any parameter value of 0 except porches as illegal (elaboration error); zero porches SHALL be supported.

Reset
REQ-032 SHALL, while RST is high, asynchronously force h = 0, v = 0, ACTIVE = 1, LINE_START = 1, FRAME_START = 1, HSYNC = ~HS_POL, VSYNC = ~VS_POL (consistent with position 0,0).
REQ-033 SHALL, on the first enabled edge after RST deasserts, present h = 1, v = 0, LINE_START = 0, FRAME_START = 0.
REQ-034 SHALL allow reset mid-line/mid-frame, returning immediately to the REQ-032 state with no partial pulses retained.

Verification
REQ-035 Small config (H 8/2/2/2, V 4/1/1/2, EN=1): h sequence 0..13 then 0; v increments when h 13->0; v 7->0 after 112 cycles; FRAME_START high once per 112 cycles.
REQ-036 Same config: HSYNC low exactly at h = 10,11; VSYNC low exactly for v = 5 (all 14 cycles of line 5); ACTIVE high for h 0..7 on v 0..3 only (32 cycles/frame).
REQ-037 HS_POL=1, VS_POL=1: HSYNC high only at h = 10,11, VSYNC high only on v = 5; reset drives both 0.
REQ-038 EN toggled 1,0,0,1 from reset: h goes 0 ->1, holds 1 for two cycles, ->2; flags unchanged during holds.
REQ-039 RST pulsed asynchronously at h = 9, v = 6 (between edges): h, v read 0 before next CLK edge, FRAME_START = 1, HSYNC/VSYNC deasserted.
REQ-040 Default 576p params: 864 x 625 = 540000 enabled cycles per frame, hsync 64 cycles starting h = 732, vsync 5 lines starting v = 581.
